// File: rtl/busy_table_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : busy_table_ctrl_pkg
// Brief   : Shared constants and types for the busy-table write controller.
// Revision: 1.0 - initial release
// ============================================================================
package busy_table_ctrl_pkg;

    localparam int c_phy_rf_depth = 128;

    typedef logic [$clog2(c_phy_rf_depth)-1:0] phys_addr_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bt_state_e;

endpackage : busy_table_ctrl_pkg
`default_nettype wire

// File: rtl/busy_table_ctrl_clr_fifo.sv
`default_nettype none
// ============================================================================
// Module  : busy_table_ctrl_clr_fifo
// Brief   : Pending-clear buffer: up to NUM_ENQ pushes and one pop per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module busy_table_ctrl_clr_fifo #(
    parameter int DEPTH   = 8,
    parameter int NUM_ENQ = 2,
    parameter int WIDTH   = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_flush,
    input  logic                             i_enq_en,
    input  logic [NUM_ENQ-1:0]               i_enq_valid,
    input  logic [NUM_ENQ-1:0][WIDTH-1:0]    i_enq_data,
    input  logic                             i_deq_en,
    output logic [WIDTH-1:0]                 o_deq_data,
    output logic [$clog2(DEPTH):0]           o_count,
    output logic                             o_full,
    output logic                             o_empty,
    output logic                             o_room
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_slot [NUM_ENQ];
    logic [CW-1:0]    w_enq_cnt;

    // Each accepted port lands after all lower-numbered accepted ports.
    always_comb begin
        w_enq_cnt = '0;
        for (int i = 0; i < NUM_ENQ; i++) begin
            w_slot[i] = r_wr_ptr + PW'(w_enq_cnt);
            if (i_enq_en && i_enq_valid[i]) begin
                w_enq_cnt = w_enq_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENQ; i++) begin
            if (i_enq_en && i_enq_valid[i]) begin
                r_mem[w_slot[i]] <= i_enq_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_enq_cnt);
            if (i_deq_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + w_enq_cnt - {{(CW-1){1'b0}}, i_deq_en};
        end
    end

    assign o_deq_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_room     = ((CW'(DEPTH) - r_count) >= CW'(NUM_ENQ));

endmodule : busy_table_ctrl_clr_fifo
`default_nettype wire

// File: rtl/busy_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : busy_table_ctrl
// Brief   : Arbitrates rename sets, writeback clears and flush walks onto the
//           single busy-table write port.
// Revision: 1.0 - initial release
// ============================================================================
module busy_table_ctrl
    import busy_table_ctrl_pkg::*;
#(
    parameter int PHY_RF_DEPTH   = c_phy_rf_depth,
    parameter int NUM_WB         = 2,
    parameter int CLR_FIFO_DEPTH = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        set_valid,
    input  logic [$clog2(PHY_RF_DEPTH)-1:0]             set_addr,
    output logic                                        set_ready,
    input  logic [NUM_WB-1:0]                           clr_valid,
    input  logic [NUM_WB-1:0][$clog2(PHY_RF_DEPTH)-1:0] clr_addr,
    output logic                                        clr_ready,
    input  logic                                        flush_req,
    output logic                                        flush_busy,
    output logic                                        bt_wr_en,
    output logic [$clog2(PHY_RF_DEPTH)-1:0]             bt_wr_addr,
    output logic                                        bt_data,
    output logic [$clog2(CLR_FIFO_DEPTH):0]             pending_clr
);

    localparam int AW = $clog2(PHY_RF_DEPTH);
    localparam logic [AW-1:0] c_last_addr = AW'(PHY_RF_DEPTH - 1);

    bt_state_e      r_state;
    bt_state_e      w_state_nxt;
    logic [AW-1:0]  r_walk;
    logic [AW-1:0]  w_walk_nxt;

    logic           r_wr_en;
    logic [AW-1:0]  r_wr_addr;
    logic           r_data;
    logic           w_wr_en_nxt;
    logic [AW-1:0]  w_wr_addr_nxt;
    logic           w_data_nxt;

    logic           w_set_ready;
    logic           w_clr_ready;
    logic           w_deq_en;
    logic           w_fifo_flush;
    logic [AW-1:0]  w_deq_addr;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic           w_fifo_room;

    busy_table_ctrl_clr_fifo #(
        .DEPTH   (CLR_FIFO_DEPTH),
        .NUM_ENQ (NUM_WB),
        .WIDTH   (AW)
    ) u_clr_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_fifo_flush),
        .i_enq_en    (w_clr_ready),
        .i_enq_valid (clr_valid),
        .i_enq_data  (clr_addr),
        .i_deq_en    (w_deq_en),
        .o_deq_data  (w_deq_addr),
        .o_count     (pending_clr),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_room      (w_fifo_room)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_walk_nxt    = r_walk;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = '0;
        w_data_nxt    = 1'b0;
        w_deq_en      = 1'b0;
        w_fifo_flush  = 1'b0;
        w_set_ready   = 1'b0;
        w_clr_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush_req) begin
                    w_fifo_flush = 1'b1;
                    w_walk_nxt   = '0;
                    w_state_nxt  = ST_FLUSH;
                end else begin
                    w_set_ready = !w_fifo_full;
                    w_clr_ready = w_fifo_room;
                    // A full buffer must drain first or writebacks would stall forever.
                    if (w_fifo_full) begin
                        w_deq_en      = 1'b1;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_deq_addr;
                    end else if (set_valid) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = set_addr;
                        w_data_nxt    = 1'b1;
                    end else if (!w_fifo_empty) begin
                        w_deq_en      = 1'b1;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = w_deq_addr;
                    end
                end
            end
            ST_FLUSH: begin
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_walk;
                if (r_walk == c_last_addr) begin
                    w_walk_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_walk_nxt = r_walk + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_walk    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_data    <= 1'b0;
        end else begin
            r_walk    <= w_walk_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_data    <= w_data_nxt;
        end
    end

    assign set_ready  = w_set_ready;
    assign clr_ready  = w_clr_ready;
    assign flush_busy = (r_state == ST_FLUSH);
    assign bt_wr_en   = r_wr_en;
    assign bt_wr_addr = r_wr_addr;
    assign bt_data    = r_data;

endmodule : busy_table_ctrl
`default_nettype wire

// File: tb/tb_busy_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_busy_table_ctrl
// Brief   : Randomized bench for busy_table_ctrl against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_busy_table_ctrl;
    import busy_table_ctrl_pkg::*;

    localparam int DEPTH = 128;
    localparam int NWB   = 2;
    localparam int FD    = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     set_valid = 1'b0;
    phys_addr_t               set_addr = '0;
    logic                     set_ready;
    logic [NWB-1:0]           clr_valid = '0;
    logic [NWB-1:0][6:0]      clr_addr = '0;
    logic                     clr_ready;
    logic                     flush_req = 1'b0;
    logic                     flush_busy;
    logic                     bt_wr_en;
    phys_addr_t               bt_wr_addr;
    logic                     bt_data;
    logic [3:0]               pending_clr;

    always #5 clk = ~clk;

    busy_table_ctrl #(
        .PHY_RF_DEPTH   (DEPTH),
        .NUM_WB         (NWB),
        .CLR_FIFO_DEPTH (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .set_valid   (set_valid),
        .set_addr    (set_addr),
        .set_ready   (set_ready),
        .clr_valid   (clr_valid),
        .clr_addr    (clr_addr),
        .clr_ready   (clr_ready),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy),
        .bt_wr_en    (bt_wr_en),
        .bt_wr_addr  (bt_wr_addr),
        .bt_data     (bt_data),
        .pending_clr (pending_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: pending clears as a queue of addresses, a flush flag and
    // the write expected on the port after the next edge.
    bit m_known = 1'b0;
    bit m_flush = 1'b0;
    int m_walk  = 0;
    int m_q[$];
    bit e_en = 1'b0;
    int e_addr = 0;
    bit e_data = 1'b0;
    bit e_rst = 1'b0;

    task automatic step(input bit r, input bit sv, input int sa, input bit [1:0] cv,
                        input int a0, input int a1, input bit fr);
        bit room;
        int addrs[2];
        @(negedge clk);
        if (m_known) begin
            check("wr_en", int'(bt_wr_en), int'(e_en));
            if (e_en || e_rst) begin
                check("wr_addr", int'(bt_wr_addr), e_addr);
                check("wr_data", int'(bt_data), int'(e_data));
            end
            check("pending_clr", int'(pending_clr), m_q.size());
            check("flush_busy", int'(flush_busy), int'(m_flush));
            check("pending_le_depth", int'(pending_clr <= 4'(FD)), 1);
        end
        rst         = r;
        set_valid   = sv;
        set_addr    = phys_addr_t'(sa);
        clr_valid   = cv;
        clr_addr[0] = 7'(a0);
        clr_addr[1] = 7'(a1);
        flush_req   = fr;
        #1;
        if (m_known) begin
            check("set_ready", int'(set_ready), int'(!m_flush && !fr && m_q.size() < FD));
            check("clr_ready", int'(clr_ready), int'(!m_flush && !fr && (FD - m_q.size()) >= NWB));
        end
        e_rst = 1'b0;
        addrs[0] = a0;
        addrs[1] = a1;
        if (r) begin
            m_known = 1'b1;
            m_flush = 1'b0;
            m_walk  = 0;
            m_q.delete();
            e_en = 1'b0; e_addr = 0; e_data = 1'b0; e_rst = 1'b1;
        end else if (!m_known) begin
            e_en = 1'b0;
        end else if (m_flush) begin
            e_en = 1'b1; e_addr = m_walk; e_data = 1'b0;
            if (m_walk == DEPTH - 1) begin
                m_flush = 1'b0;
                m_walk  = 0;
            end else begin
                m_walk++;
            end
        end else if (fr) begin
            m_q.delete();
            m_flush = 1'b1;
            m_walk  = 0;
            e_en    = 1'b0;
        end else begin
            room = ((FD - m_q.size()) >= NWB);
            if (m_q.size() == FD) begin
                e_en = 1'b1; e_data = 1'b0; e_addr = m_q.pop_front();
            end else if (sv) begin
                e_en = 1'b1; e_data = 1'b1; e_addr = sa;
            end else if (m_q.size() > 0) begin
                e_en = 1'b1; e_data = 1'b0; e_addr = m_q.pop_front();
            end else begin
                e_en = 1'b0;
            end
            if (room) begin
                for (int i = 0; i < NWB; i++) begin
                    if (cv[i]) m_q.push_back(addrs[i]);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b0);
    endtask

    initial begin
        step(1'b1, 1'b0, 0, 2'b00, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 2'b00, 0, 0, 1'b0);
        idle(2);

        // Single set to register 5.
        step(1'b0, 1'b1, 5, 2'b00, 0, 0, 1'b0);
        idle(2);

        // Two clears in one cycle drain in port order.
        step(1'b0, 1'b0, 0, 2'b11, 7, 9, 1'b0);
        idle(4);

        // Continuous sets while writebacks fill the buffer.
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, $urandom_range(0, 127), 2'b11,
                 $urandom_range(0, 127), $urandom_range(0, 127), 1'b0);
        idle(12);

        // Flush with three pending clears; stray flush_req during the walk.
        step(1'b0, 1'b1, 11, 2'b11, 20, 21, 1'b0);
        step(1'b0, 1'b1, 12, 2'b01, 22, 23, 1'b0);
        step(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        for (int i = 0; i < 135; i++)
            step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 127), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 127), $urandom_range(0, 127), (i == 60));
        idle(3);

        // Reset lands while the walk is at address 40.
        step(1'b0, 1'b0, 0, 2'b00, 0, 0, 1'b1);
        idle(40);
        step(1'b1, 1'b0, 0, 2'b00, 0, 0, 1'b0);
        idle(5);

        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 599) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 127),
                 2'($urandom_range(0, 3)), $urandom_range(0, 127), $urandom_range(0, 127),
                 ($urandom_range(0, 149) == 0));
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_busy_table_ctrl
`default_nettype wire

// File: doc/busy_table_ctrl.md
BUSY_TABLE_CTRL -- requirements
Module: busy_table_ctrl

Interface
REQ-001 SHALL have parameter PHY_RF_DEPTH, default 128, number of physical registers tracked.
REQ-002 SHALL have parameter NUM_WB, default 2, number of writeback clear ports.
REQ-003 SHALL have parameter CLR_FIFO_DEPTH, default 8, pending-clear buffer entries (power of two, >= NUM_WB).
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port set_valid  input  1  rename stage requests marking a register busy.
REQ-007 SHALL have port set_addr  input  $clog2(PHY_RF_DEPTH)  register to mark busy.
REQ-008 SHALL have port set_ready  output  1  set request accepted this cycle when high together with set_valid.
REQ-009 SHALL have port clr_valid  input  NUM_WB  per-port writeback requests to mark a register ready.
REQ-010 SHALL have port clr_addr  input  NUM_WB x $clog2(PHY_RF_DEPTH)  per-port register to mark ready.
REQ-011 SHALL have port clr_ready  output  1  all clear ports accepted this cycle when high.
REQ-012 SHALL have port flush_req  input  1  pipeline flush; clear the whole table.
REQ-013 SHALL have port flush_busy  output  1  flush walk in progress.
REQ-014 SHALL have port bt_wr_en  output  1  busy-table write enable.
REQ-015 SHALL have port bt_wr_addr  output  $clog2(PHY_RF_DEPTH)  busy-table write address.
REQ-016 SHALL have port bt_data  output  1  busy-table write data (1 = busy, 0 = ready).
REQ-017 SHALL have port pending_clr  output  $clog2(CLR_FIFO_DEPTH)+1  current clear-FIFO occupancy.

Function
REQ-018 SHALL implement FSM states IDLE and FLUSH; IDLE -> FLUSH on flush_req; FLUSH -> IDLE after the write to address PHY_RF_DEPTH-1.
REQ-019 SHALL drive bt_wr_en/bt_wr_addr/bt_data from registers: an operation selected in cycle N appears on the write port in cycle N+1.
REQ-020 SHALL, in IDLE, enqueue all valid clear ports into the FIFO in ascending port order when clr_ready is high; clr_ready high iff free slots >= NUM_WB and state is IDLE and flush_req low.
REQ-021 SHALL arbitrate the single write port per cycle in IDLE: FIFO full -> drain one clear (set_ready low); else set_valid -> write set (set_ready high); else FIFO non-empty -> drain one clear; else bt_wr_en low next cycle.
REQ-022 SHALL drive set_ready high in IDLE unless FIFO is full or flush_req is high; set writes bt_data=1 at set_addr.
REQ-023 SHALL drain clears oldest first, writing bt_data=0 at the dequeued address.
REQ-024 SHALL allow enqueue and dequeue in the same cycle; occupancy = old + enqueued - dequeued; pointers wrap modulo CLR_FIFO_DEPTH.
REQ-025 SHALL, on flush_req in IDLE, discard FIFO contents (pending_clr=0 next cycle), ignore same-cycle set/clear requests, and enter FLUSH.
REQ-026 SHALL, in FLUSH, write bt_data=0 to addresses 0,1,...,PHY_RF_DEPTH-1, one per cycle, via a walk counter; flush_busy high the whole FLUSH state.
REQ-027 SHALL hold set_ready and clr_ready low in FLUSH; flush_req asserted during FLUSH SHALL be ignored (no restart).
REQ-028 SHALL not check address ordering between sets and clears; caller guarantees a register is not freed with a clear still pending.

Reset
REQ-029 SHALL, on rst, enter IDLE, empty the FIFO, zero the walk counter, and drive bt_wr_en=0, bt_wr_addr=0, bt_data=0, flush_busy=0, pending_clr=0 from the next edge.
REQ-030 SHALL let rst abort a FLUSH walk mid-way; no further table writes after reset.
REQ-031 SHALL not reset FIFO storage array contents, only pointers/count.

Structure
REQ-032 SHALL place PHY_RF_DEPTH default, phys-reg address typedef and FSM state enum in the shared Qu package.
REQ-033 SHALL implement the clear buffer as one sub-module, clr_fifo (multi-enqueue, single-dequeue, synchronous).

Verification
REQ-034 SHALL cover: set_valid=1 addr 5, FIFO empty -> next cycle bt_wr_en=1, addr 5, data 1.
REQ-035 SHALL cover: clr ports 0/1 addrs 7/9 with set_valid idle -> clear writes addr 7 then 9 on consecutive cycles, data 0.
REQ-036 SHALL cover: continuous set_valid while clears fill FIFO to 8 -> set_ready drops, one clear drains, set_ready returns; pending_clr never exceeds 8.
REQ-037 SHALL cover: flush_req with 3 pending clears -> pending_clr=0, flush_busy high 128 cycles, writes addr 0..127 data 0, then IDLE with ready outputs high.
REQ-038 SHALL cover: rst asserted at walk address 40 -> bt_wr_en=0 next cycle, IDLE, flush_busy=0, no further writes.
